// File: rtl/pmod_mic_array_interface.sv
// Multi-channel serial ADC front end for PMOD microphones: shared ncs/sclock generated by a
// clock-enable divider, parallel per-channel shift-in, one-cycle valid strobe and overrun flag.
module pmod_mic_array_interface #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned CLK_DIV      = 16,
    parameter int unsigned FRAME_BITS   = 16,
    parameter int unsigned DATA_BITS    = 12,
    parameter int unsigned QUIET_CYCLES = 32
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [CHANNELS-1:0]           sdata_i,
    input  logic                          start_i,
    input  logic                          continuous_i,
    input  logic                          clear_overrun_i,
    output logic                          sclock_o,
    output logic                          ncs_o,
    output logic                          busy_o,
    output logic [CHANNELS*DATA_BITS-1:0] data_o,
    output logic                          data_valid_o,
    output logic                          overrun_o,
    output logic [15:0]                   sample_count_o
);

    localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BitW   = $clog2(FRAME_BITS + 1);
    localparam int unsigned QuietW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

    localparam logic [DivW-1:0]   DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [BitW-1:0]   BitLast   = BitW'(FRAME_BITS);
    localparam logic [QuietW-1:0] QuietLast = QuietW'(QUIET_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StLow, StHigh, StQuiet} state_e;

    state_e                        state_q;
    logic [DivW-1:0]               div_q;
    logic [BitW-1:0]               bit_q;
    logic [QuietW-1:0]             quiet_q;
    logic [FRAME_BITS-1:0]         sr_q [CHANNELS];
    logic                          sclock_q;
    logic                          ncs_q;
    logic                          busy_q;
    logic [CHANNELS*DATA_BITS-1:0] data_q;
    logic                          valid_q;
    logic                          overrun_q;
    logic                          overrun_d;
    logic [15:0]                   count_q;
    logic                          div_last;

    assign div_last = (div_q == DivLast);

    // A start that cannot be honoured takes priority over a same-cycle clear.
    always_comb begin
        overrun_d = overrun_q;
        if (clear_overrun_i) overrun_d = 1'b0;
        if (start_i && (state_q != StIdle)) overrun_d = 1'b1;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_q     <= '0;
            quiet_q   <= '0;
            sclock_q  <= 1'b1;
            ncs_q     <= 1'b1;
            busy_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) sr_q[i] <= '0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= overrun_d;
            case (state_q)
                StIdle: begin
                    if (start_i || continuous_i) begin
                        state_q <= StSetup;
                        ncs_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        div_q   <= '0;
                        bit_q   <= '0;
                        for (int unsigned i = 0; i < CHANNELS; i++) sr_q[i] <= '0;
                    end
                end
                StSetup: begin
                    if (div_last) begin
                        state_q  <= StLow;
                        sclock_q <= 1'b0;
                        div_q    <= '0;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StLow: begin
                    // Last low cycle: this edge is the sclock rising edge, sample now.
                    if (div_last) begin
                        state_q  <= StHigh;
                        sclock_q <= 1'b1;
                        div_q    <= '0;
                        bit_q    <= bit_q + 1'b1;
                        for (int unsigned i = 0; i < CHANNELS; i++) begin
                            sr_q[i] <= {sr_q[i][FRAME_BITS-2:0], sdata_i[i]};
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StHigh: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (bit_q == BitLast) begin
                            ncs_q   <= 1'b1;
                            valid_q <= 1'b1;
                            count_q <= count_q + 16'd1;
                            quiet_q <= '0;
                            for (int unsigned i = 0; i < CHANNELS; i++) begin
                                data_q[i*DATA_BITS +: DATA_BITS] <= sr_q[i][DATA_BITS-1:0];
                            end
                            if (QUIET_CYCLES == 0) begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= StQuiet;
                            end
                        end else begin
                            state_q  <= StLow;
                            sclock_q <= 1'b0;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StQuiet: begin
                    if (quiet_q == QuietLast) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        quiet_q <= quiet_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sclock_o       = sclock_q;
    assign ncs_o          = ncs_q;
    assign busy_o         = busy_q;
    assign data_o         = data_q;
    assign data_valid_o   = valid_q;
    assign overrun_o      = overrun_q;
    assign sample_count_o = count_q;

endmodule

// File: tb/tb_pmod_mic_array_interface.sv
// Scoreboard bench for pmod_mic_array_interface: mic models push expected samples per frame,
// monitors compare on data_valid; one default instance and one fast 4-channel instance.
module tb_pmod_mic_array_interface;

    localparam int CH0 = 2, DIV0 = 16, Q0 = 32;
    localparam int CH1 = 4, DIV1 = 1,  Q1 = 0;
    localparam int FB = 16, DB = 12;
    localparam int FRAME0 = DIV0 * (2 * FB + 1);
    localparam int PER0   = FRAME0 + Q0 + 1;
    localparam int FRAME1 = DIV1 * (2 * FB + 1);
    localparam int PER1   = FRAME1 + Q1 + 1;

    typedef struct {
        logic [63:0] data;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instance 0: defaults ----------------
    logic [CH0-1:0]    sdata0 = '0;
    logic              start0, cont0, clr0;
    logic              sclk0, ncs0, busy0, dv0, ovr0;
    logic [CH0*DB-1:0] data0;
    logic [15:0]       cnt0;

    pmod_mic_array_interface #(
        .CHANNELS(CH0), .CLK_DIV(DIV0), .FRAME_BITS(FB), .DATA_BITS(DB), .QUIET_CYCLES(Q0)
    ) dut0 (
        .clock_i(clk), .reset_i(rst), .sdata_i(sdata0), .start_i(start0),
        .continuous_i(cont0), .clear_overrun_i(clr0), .sclock_o(sclk0), .ncs_o(ncs0),
        .busy_o(busy0), .data_o(data0), .data_valid_o(dv0), .overrun_o(ovr0),
        .sample_count_o(cnt0)
    );

    // ---------------- instance 1: 4 channels, fastest divider, no quiet ----------------
    logic [CH1-1:0]    sdata1 = '0;
    logic              start1, cont1, clr1;
    logic              sclk1, ncs1, busy1, dv1, ovr1;
    logic [CH1*DB-1:0] data1;
    logic [15:0]       cnt1;

    pmod_mic_array_interface #(
        .CHANNELS(CH1), .CLK_DIV(DIV1), .FRAME_BITS(FB), .DATA_BITS(DB), .QUIET_CYCLES(Q1)
    ) dut1 (
        .clock_i(clk), .reset_i(rst), .sdata_i(sdata1), .start_i(start1),
        .continuous_i(cont1), .clear_overrun_i(clr1), .sclock_o(sclk1), .ncs_o(ncs1),
        .busy_o(busy1), .data_o(data1), .data_valid_o(dv1), .overrun_o(ovr1),
        .sample_count_o(cnt1)
    );

    // ---------------- mic models + expected-value generation ----------------
    logic [FB-1:0] word0 [CH0];
    logic [FB-1:0] fw0   [CH0];
    bit            fw0_v = 0;
    int            bidx0, rises0;
    longint        ncs0_fall;
    logic [15:0]   cnt_model0 = 0;
    exp_t          q0[$];
    exp_t          m0, p0;

    logic [FB-1:0] word1 [CH1];
    int            bidx1, rises1;
    longint        ncs1_fall;
    logic [15:0]   cnt_model1 = 0;
    exp_t          q1[$];
    exp_t          m1, p1;

    always @(negedge ncs0) begin
        ncs0_fall = cyc;
        rises0    = 0;
        bidx0     = FB - 1;
        m0.data   = '0;
        for (int c = 0; c < CH0; c++) begin
            word0[c] = fw0_v ? fw0[c] : FB'($urandom);
            m0.data[c*DB +: DB] = word0[c][DB-1:0];
        end
        fw0_v      = 0;
        cnt_model0 = cnt_model0 + 16'd1;
        m0.cnt     = cnt_model0;
        q0.push_back(m0);
    end

    always @(negedge ncs1) begin
        ncs1_fall = cyc;
        rises1    = 0;
        bidx1     = FB - 1;
        m1.data   = '0;
        for (int c = 0; c < CH1; c++) begin
            word1[c] = FB'($urandom);
            m1.data[c*DB +: DB] = word1[c][DB-1:0];
        end
        cnt_model1 = cnt_model1 + 16'd1;
        m1.cnt     = cnt_model1;
        q1.push_back(m1);
    end

    // Mics present the next bit (MSB first) on each sclock fall.
    always @(negedge sclk0) if (ncs0 === 1'b0 && bidx0 >= 0) begin
        for (int c = 0; c < CH0; c++) sdata0[c] = word0[c][bidx0];
        bidx0--;
    end

    always @(negedge sclk1) if (ncs1 === 1'b0 && bidx1 >= 0) begin
        for (int c = 0; c < CH1; c++) sdata1[c] = word1[c][bidx1];
        bidx1--;
    end

    always @(posedge sclk0) if (!rst && ncs0 === 1'b0) rises0++;
    always @(posedge sclk1) if (!rst && ncs1 === 1'b0) rises1++;

    always @(posedge ncs0) if (!rst) begin
        check("ncs0_low_cycles", 64'(cyc - ncs0_fall), FRAME0);
        check("sclk0_pulses", rises0, FB);
    end

    always @(posedge ncs1) if (!rst) begin
        check("ncs1_low_cycles", 64'(cyc - ncs1_fall), FRAME1);
        check("sclk1_pulses", rises1, FB);
    end

    // ---------------- monitors ----------------
    logic   dv0_prev = 1'b0, dv1_prev = 1'b0;
    longint dvt0[$], dvt1[$];

    always @(negedge clk) begin
        if (rst) begin
            dv0_prev = 1'b0;
            dv1_prev = 1'b0;
        end else begin
            if (dv0 === 1'b1) begin
                check("dv0_single_cycle", dv0_prev, 0);
                dvt0.push_back(cyc);
                if (q0.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dv0_unexpected: got frame %0h expected none", data0);
                end else begin
                    p0 = q0.pop_front();
                    check("data0", data0, p0.data);
                    check("count0", cnt0, p0.cnt);
                end
            end
            if (dv1 === 1'b1) begin
                check("dv1_single_cycle", dv1_prev, 0);
                dvt1.push_back(cyc);
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dv1_unexpected: got frame %0h expected none", data1);
                end else begin
                    p1 = q1.pop_front();
                    check("data1", data1, p1.data);
                    check("count1", cnt1, p1.cnt);
                end
            end
            dv0_prev = dv0;
            dv1_prev = dv1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        dvt0.delete();
        dvt1.delete();
        cnt_model0 = 0;
        cnt_model1 = 0;
    endtask

    task automatic wait_idle0(input int maxc);
        int n = 0;
        while (busy0 !== 1'b0 && n < maxc) begin
            tick(1);
            n++;
        end
        check("idle0_reached", busy0, 0);
    endtask

    task automatic wait_idle1(input int maxc);
        int n = 0;
        while (busy1 !== 1'b0 && n < maxc) begin
            tick(1);
            n++;
        end
        check("idle1_reached", busy1, 0);
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        start0 = 0; cont0 = 0; clr0 = 0;
        start1 = 0; cont1 = 0; clr1 = 0;
        tick(3);
        check("rst_ncs0", ncs0, 1);
        check("rst_sclk0", sclk0, 1);
        check("rst_busy0", busy0, 0);
        check("rst_data0", data0, 0);
        check("rst_dv0", dv0, 0);
        check("rst_ovr0", ovr0, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_ncs1", ncs1, 1);
        check("rst_sclk1", sclk1, 1);
        check("rst_busy1", busy1, 0);
        rst = 1'b0;
        tick(2);

        // Single shot with known words
        fw0[0] = 16'h0ABC;
        fw0[1] = 16'h0123;
        fw0_v  = 1;
        pulse_start0();
        check("start_ncs_low", ncs0, 0);
        check("start_busy", busy0, 1);
        wait_idle0(2000);
        check("single_data", data0, 24'h123ABC);
        check("single_count", cnt0, 1);

        // Upper frame bits are discarded
        fw0[0] = 16'hFFFF;
        fw0[1] = 16'h5A5A;
        fw0_v  = 1;
        pulse_start0();
        wait_idle0(2000);
        check("trunc_ch0", data0[11:0], 12'hFFF);
        check("trunc_ch1", data0[23:12], 12'hA5A);
        check("trunc_count", cnt0, 2);

        // Overrun
        pulse_start0();
        tick(99);
        pulse_start0();
        check("overrun_set", ovr0, 1);
        tick(20);
        start0 = 1'b1;
        clr0   = 1'b1;
        tick(1);
        start0 = 1'b0;
        clr0   = 1'b0;
        check("overrun_set_wins", ovr0, 1);
        wait_idle0(2000);
        tick(10);
        check("overrun_no_extra_frame", cnt0, 3);
        check("overrun_busy_low", busy0, 0);
        clr0 = 1'b1;
        tick(1);
        clr0 = 1'b0;
        check("overrun_cleared", ovr0, 0);

        // Asynchronous reset in the middle of a LOW phase
        pulse_start0();
        tick(DIV0 + 5);
        check("midlow_sclk", sclk0, 0);
        check("midlow_ncs", ncs0, 0);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_ncs", ncs0, 1);
        check("async_rst_sclk", sclk0, 1);
        check("async_rst_data", data0, 0);
        check("async_rst_cnt", cnt0, 0);
        check("async_rst_busy", busy0, 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Continuous: three frames, dropping the level mid-frame 3
        cont0  = 1'b1;
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        check("cont_start_no_overrun", ovr0, 0);
        n = 0;
        while (dvt0.size() < 2 && n < 3 * PER0) begin
            tick(1);
            n++;
        end
        tick(200);
        cont0 = 1'b0;
        wait_idle0(2000);
        check("cont_frames", dvt0.size(), 3);
        if (dvt0.size() >= 3) begin
            check("cont_period_1", 64'(dvt0[1] - dvt0[0]), PER0);
            check("cont_period_2", 64'(dvt0[2] - dvt0[1]), PER0);
        end
        check("cont_count", cnt0, 3);
        tick(PER0 + 50);
        check("cont_stays_idle", busy0, 0);
        check("cont_final_count", cnt0, 3);

        // Fast 4-channel instance, continuous
        cont1  = 1'b1;
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        n = 0;
        while (dvt1.size() < 4 && n < 6 * PER1) begin
            tick(1);
            n++;
        end
        cont1 = 1'b0;
        wait_idle1(200);
        tick(5);
        check("fast_frames", dvt1.size(), 5);
        if (dvt1.size() >= 5) begin
            for (int i = 1; i < 5; i++) check("fast_period", 64'(dvt1[i] - dvt1[i-1]), PER1);
        end
        check("fast_count", cnt1, 5);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
